// File: rtl/nmi_tmo_bridge.sv
// Registered NMI request slice with bus timeout; optional error log via NMI_TMO_ERR_LOG_EN.
// Latency: request forwarded 1 cycle after m_valid_i, response 1 cycle after s_ready_i or timeout.
// Backpressure: one outstanding access; new requests are only taken in IDLE.
module nmi_tmo_bridge #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m_valid_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_wdata_i,
    input  logic [3:0]  m_wstrb_i,
    output logic [31:0] m_rdata_o,
    output logic        m_ready_o,
    output logic        s_valid_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ready_i,
    output logic        err_o,
    input  logic        err_clr_i,
    output logic [31:0] err_addr_o,
    output logic [7:0]  err_cnt_o
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tmo_hit;

    // A ready on the final counted cycle takes precedence over the timeout.
    assign tmo_hit = (state == REQ) && !s_ready_i && (cnt == TMO_LAST);

    // m_rdata_o doubles as the response register so it holds between transactions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            s_valid_o <= 1'b0;
            m_ready_o <= 1'b0;
            m_rdata_o <= '0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            s_wstrb_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m_ready_o <= 1'b0;
                    if (m_valid_i) begin
                        s_addr_o  <= m_addr_i;
                        s_wdata_o <= m_wdata_i;
                        s_wstrb_o <= m_wstrb_i;
                        cnt       <= '0;
                        s_valid_o <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // Leaves REQ at TMO_LAST at the latest, so cnt never exceeds TIMEOUT_CYC.
                    cnt <= cnt + CW'(1);
                    if (s_ready_i) begin
                        m_rdata_o <= s_rdata_i;
                        s_valid_o <= 1'b0;
                        m_ready_o <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == TMO_LAST) begin
                        m_rdata_o <= ERR_RDATA;
                        s_valid_o <= 1'b0;
                        m_ready_o <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    m_ready_o <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    s_valid_o <= 1'b0;
                    m_ready_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (tmo_hit) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

`ifdef NMI_TMO_ERR_LOG_EN
    logic [31:0] err_addr_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (tmo_hit) begin
            err_addr_q <= s_addr_o;
            if (err_clr_i) begin
                err_cnt_q <= 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end else if (err_clr_i) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;
`else
    assign err_addr_o = '0;
    assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_nmi_tmo_bridge.sv
// Bench for nmi_tmo_bridge with TIMEOUT_CYC = 16; responses are matched against a queue of expected read data.
module tb_nmi_tmo_bridge;

    localparam int          TMO = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef NMI_TMO_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m_valid_i;
    logic [31:0] m_addr_i;
    logic [31:0] m_wdata_i;
    logic [3:0]  m_wstrb_i;
    logic [31:0] m_rdata_o;
    logic        m_ready_o;
    logic        s_valid_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic [31:0] s_rdata_i;
    logic        s_ready_i;
    logic        err_o;
    logic        err_clr_i;
    logic [31:0] err_addr_o;
    logic [7:0]  err_cnt_o;

    nmi_tmo_bridge #(
        .TIMEOUT_CYC(TMO),
        .ERR_RDATA  (ERR)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m_valid_i (m_valid_i),
        .m_addr_i  (m_addr_i),
        .m_wdata_i (m_wdata_i),
        .m_wstrb_i (m_wstrb_i),
        .m_rdata_o (m_rdata_o),
        .m_ready_o (m_ready_o),
        .s_valid_o (s_valid_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o),
        .s_wstrb_o (s_wstrb_o),
        .s_rdata_i (s_rdata_i),
        .s_ready_i (s_ready_i),
        .err_o     (err_o),
        .err_clr_i (err_clr_i),
        .err_addr_o(err_addr_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    // Reference model of the sticky error state.
    logic        mdl_err;
    logic [31:0] mdl_addr;
    logic [7:0]  mdl_cnt;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_err_state(input string tag);
        check({tag, "_err"}, {31'd0, err_o}, {31'd0, mdl_err});
        check({tag, "_eaddr"}, err_addr_o, LOG_EN ? mdl_addr : 32'd0);
        check({tag, "_ecnt"}, {24'd0, err_cnt_o}, LOG_EN ? {24'd0, mdl_cnt} : 32'd0);
    endtask

    task automatic model_clear();
        mdl_err  = 1'b0;
        mdl_addr = '0;
        mdl_cnt  = '0;
    endtask

    // Called at a negedge in IDLE; rdy_cyc = 0 means the wrapper never answers.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int rdy_cyc, input logic [31:0] sdat, input int clr_cyc,
                           input bit chk_stable, input bit chk_log);
        bit          tmo;
        bit          done;
        int          exp_lat;
        logic [31:0] exp_d;
        tmo     = (rdy_cyc < 1) || (rdy_cyc > TMO);
        exp_lat = tmo ? TMO + 1 : rdy_cyc + 1;
        exp_q.push_back(tmo ? ERR : sdat);
        m_valid_i = 1'b1;
        m_addr_i  = addr;
        m_wdata_i = wdata;
        m_wstrb_i = wstrb;
        @(negedge clk_i);
        m_valid_i = 1'b0;
        m_addr_i  = $urandom;
        m_wdata_i = $urandom;
        m_wstrb_i = 4'($urandom);
        done = 1'b0;
        for (int cyc = 1; cyc <= TMO + 4 && !done; cyc++) begin
            if (m_ready_o) begin
                check("latency", 32'(cyc), 32'(exp_lat));
                if (exp_q.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("rdata", m_rdata_o, exp_d);
                    last_rdata = exp_d;
                end
                if (clr_cyc > 0) model_clear();
                if (tmo) begin
                    mdl_err  = 1'b1;
                    mdl_addr = addr;
                    if (mdl_cnt != 8'hFF) mdl_cnt = mdl_cnt + 8'd1;
                end
                if (chk_log) check_err_state("resp");
                done = 1'b1;
            end else if (chk_stable) begin
                check("s_valid", {31'd0, s_valid_o}, 32'd1);
                check("s_addr", s_addr_o, addr);
                check("s_wdata", s_wdata_o, wdata);
                check("s_wstrb", {28'd0, s_wstrb_o}, {28'd0, wstrb});
            end
            s_ready_i = (cyc == rdy_cyc);
            s_rdata_i = s_ready_i ? sdat : $urandom;
            err_clr_i = (cyc == clr_cyc);
            @(negedge clk_i);
        end
        if (!done) check("resp_timeout", 32'd0, 32'd1);
        s_ready_i = 1'b0;
        err_clr_i = 1'b0;
        if (chk_stable) begin
            check("single_pulse", {31'd0, m_ready_o}, 32'd0);
            check("s_valid_idle", {31'd0, s_valid_o}, 32'd0);
            check("rdata_hold", m_rdata_o, last_rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        m_valid_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
        s_rdata_i = '0; s_ready_i = 1'b0; err_clr_i = 1'b0;
        model_clear();
        last_rdata = '0;
        repeat (3) @(negedge clk_i);
        check("rst_s_valid", {31'd0, s_valid_o}, 32'd0);
        check("rst_m_ready", {31'd0, m_ready_o}, 32'd0);
        check("rst_m_rdata", m_rdata_o, 32'd0);
        check("rst_s_addr", s_addr_o, 32'd0);
        check("rst_s_wdata", s_wdata_o, 32'd0);
        check("rst_s_wstrb", {28'd0, s_wstrb_o}, 32'd0);
        check_err_state("rst");
        rst_i = 1'b0;
        @(negedge clk_i);

        // GPIO read, minimum round trip
        run_txn(32'h1000_0004, 32'h0, 4'b0000, 1, 32'h0000_00A5, 0, 1'b1, 1'b1);
        // PSRAM write, ready after 6 cycles
        run_txn(32'h4000_0010, 32'h1234_5678, 4'b1111, 6, 32'h0BAD_F00D, 0, 1'b1, 1'b1);
        // Unmapped read times out
        run_txn(32'h2000_0000, 32'h0, 4'b0000, 0, 32'h0, 0, 1'b1, 1'b1);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        model_clear();
        check_err_state("clr1");
        // Ready on the final timeout cycle wins
        run_txn(32'h1000_0008, 32'h0, 4'b0000, TMO, 32'h5A5A_0016, 0, 1'b1, 1'b1);

        // Reset during the third REQ cycle
        exp_q.push_back(32'hFFFF_FFFF);
        m_valid_i = 1'b1; m_addr_i = 32'h3000_0000; m_wstrb_i = 4'b0011;
        @(negedge clk_i);
        m_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_s_valid_before", {31'd0, s_valid_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        model_clear();
        last_rdata = '0;
        check("mid_s_valid_after", {31'd0, s_valid_o}, 32'd0);
        check("mid_m_ready", {31'd0, m_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("mid_no_pulse", {31'd0, m_ready_o}, 32'd0);
        end
        run_txn(32'h1000_000C, 32'h0, 4'b0000, 3, 32'hC0FF_EE01, 0, 1'b1, 1'b1);

        // Mixed random traffic, some of which times out
        for (int i = 0; i < 8; i++)
            run_txn($urandom, $urandom, 4'($urandom), $urandom_range(0, 20), $urandom, 0, 1'b1, 1'b1);

        // Clear arriving in the same cycle as a timeout
        run_txn(32'h2000_0000, 32'h0, 4'b0000, 0, 32'h0, 0, 1'b0, 1'b0);
        run_txn(32'h2000_0100, 32'h0, 4'b0000, 0, 32'h0, TMO, 1'b0, 1'b1);

        // Saturation then clear
        for (int i = 0; i < 300; i++)
            run_txn(32'h2000_0000 + 32'(i * 4), 32'h0, 4'b0000, 0, 32'h0, 0, 1'b0, 1'b0);
        check_err_state("sat");
        check("sat_cnt_abs", {24'd0, err_cnt_o}, LOG_EN ? 32'd255 : 32'd0);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        model_clear();
        check_err_state("clr2");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
